// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the MIPS core.
// Latency: one cycle from the returned word to IF/ID. Sustains one instruction per cycle.
// Backpressure: a decode stall parks one returned word in a hold buffer and stops requests.
module fetch_stage #(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst_lv1,
  output logic [ADDR_W-1:0] pc4_lv1,
  output logic              valid_lv1
);

  // FETCH: request in flight; HOLD: word parked, no request; KILL: waiting out a request whose word is discarded
  typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] tgt;
  logic [31:0]       hbuf;
  logic [ADDR_W-1:0] hpc4;

  logic [ADDR_W-1:0] addr_inc;
  logic              load_fetch;
  logic              load_hold;

  assign addr_inc  = req_addr + ADDR_W'(4);
  assign imem_addr = req_addr;
  assign imem_req  = !rst && (state != HOLD);

  // A word enters IF/ID only when nothing of higher priority (redirect, flush, stall) is active
  assign load_fetch = (state == FETCH) && imem_ready && !redirect && !flush && !stall;
  assign load_hold  = (state == HOLD) && !redirect && !flush && !stall;

  // Fetch control: address sequencing, hold buffer capture, redirect tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      req_addr <= RESET_PC;
      tgt      <= RESET_PC;
      hbuf     <= '0;
      hpc4     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            // A request already accepted by imem cannot be withdrawn; wait it out in KILL
            if (imem_ready) begin
              req_addr <= redirect_pc;
            end else begin
              tgt   <= redirect_pc;
              state <= KILL;
            end
          end else if (flush) begin
            // Word dropped and address kept, so the same instruction is refetched
            req_addr <= req_addr;
          end else if (imem_ready) begin
            req_addr <= addr_inc;
            if (stall) begin
              hbuf  <= imem_rdata;
              hpc4  <= addr_inc;
              state <= HOLD;
            end
          end
        end
        KILL: begin
          if (imem_ready) begin
            req_addr <= redirect ? redirect_pc : tgt;
            state    <= FETCH;
          end else if (redirect) begin
            tgt <= redirect_pc;
          end
        end
        HOLD: begin
          if (redirect) begin
            req_addr <= redirect_pc;
            state    <= FETCH;
          end else if (flush) begin
            // Parked word is squashed too; rewind so it is fetched again
            req_addr <= hpc4 - ADDR_W'(4);
            state    <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // IF/ID register: load a new word, insert a bubble, or hold under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_lv1  <= '0;
      pc4_lv1   <= '0;
      valid_lv1 <= 1'b0;
    end else if (load_fetch) begin
      inst_lv1  <= imem_rdata;
      pc4_lv1   <= addr_inc;
      valid_lv1 <= 1'b1;
    end else if (load_hold) begin
      inst_lv1  <= hbuf;
      pc4_lv1   <= hpc4;
      valid_lv1 <= 1'b1;
    end else if (flush || !stall) begin
      inst_lv1  <= '0;
      valid_lv1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF/ID words.
// Words expected to reach decode are queued when imem returns them and compared on load.
// Direct checks cover reset, stall/hold, redirect during a pending request, flush, reset in KILL and PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] inst_lv1;
  logic [31:0] pc4_lv1;
  logic        valid_lv1;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic kill_pend = 1'b0;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst_lv1(inst_lv1), .pc4_lv1(pc4_lv1), .valid_lv1(valid_lv1)
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed function of the address
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: predict the handshake at negedge, then compare any newly loaded IF/ID word
  task automatic cycle();
    logic        hs;
    logic        drop;
    logic        p_ok;
    logic [63:0] e;
    @(negedge clk);
    hs   = imem_req && imem_ready;
    drop = redirect || flush || kill_pend || rst;
    if (hs && !drop) exp_q.push_back({imem_rdata, imem_addr + 32'd4});
    if (rst) kill_pend = 1'b0;
    else if (redirect && imem_req && !imem_ready) kill_pend = 1'b1;
    else if (hs) kill_pend = 1'b0;
    p_ok = !rst && !stall && !flush;
    @(posedge clk);
    #1;
    if (p_ok && valid_lv1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {31'd0, valid_lv1}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_inst", inst_lv1, e[63:32]);
        check("sb_pc4", pc4_lv1, e[31:0]);
      end
    end
  endtask

  initial begin
    // Reset held for two cycles
    cycle();
    cycle();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, valid_lv1}, 32'd0);
    check("rst_inst", inst_lv1, 32'd0);
    check("rst_pc4", pc4_lv1, 32'd0);
    rst = 1'b0;
    imem_ready = 1'b1;
    #1;
    check("rel_req", {31'd0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'd0);

    // Back-to-back fetch of words at 0 and 4
    cycle();
    check("s0_pc4", pc4_lv1, 32'd4);
    cycle();
    check("s1_pc4", pc4_lv1, 32'd8);
    check("s1_addr", imem_addr, 32'd8);

    // Stall while the word at 8 returns: park it, stop requesting
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_pc4", pc4_lv1, 32'd8);
      check("hold_valid", {31'd0, valid_lv1}, 32'd1);
    end
    stall = 1'b0;
    cycle();
    check("rel_pc4", pc4_lv1, 32'd12);
    check("rel_inst", inst_lv1, 32'h0000_0008 ^ 32'hA5A5_0000);
    check("rel_next_addr", imem_addr, 32'd12);
    cycle();
    check("addr_0x10", imem_addr, 32'h10);

    // Redirect while the request at 0x10 is still pending
    imem_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    check("kill_addr0", imem_addr, 32'h10);
    check("kill_valid0", {31'd0, valid_lv1}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("kill_addr", imem_addr, 32'h10);
      check("kill_req", {31'd0, imem_req}, 32'd1);
    end
    imem_ready = 1'b1;
    cycle();
    check("kill_drop_valid", {31'd0, valid_lv1}, 32'd0);
    check("kill_new_addr", imem_addr, 32'h40);
    cycle();
    check("tgt_pc4", pc4_lv1, 32'h44);

    // Flush overrides stall and squashes a valid IF/ID entry
    check("pre_flush_valid", {31'd0, valid_lv1}, 32'd1);
    stall = 1'b1;
    flush = 1'b1;
    cycle();
    stall = 1'b0;
    flush = 1'b0;
    check("flush_valid", {31'd0, valid_lv1}, 32'd0);
    check("flush_inst", inst_lv1, 32'd0);
    check("flush_refetch", imem_addr, 32'h44);
    cycle();
    check("post_flush_pc4", pc4_lv1, 32'h48);

    // Enter KILL with target 0x80, then reset: target must be forgotten
    imem_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    cycle();
    redirect = 1'b0;
    rst = 1'b1;
    cycle();
    check("rk_req", {31'd0, imem_req}, 32'd0);
    check("rk_addr", imem_addr, 32'd0);
    check("rk_valid", {31'd0, valid_lv1}, 32'd0);
    rst = 1'b0;
    imem_ready = 1'b1;
    cycle();
    check("rk_next_addr", imem_addr, 32'd4);

    // Address wrap from the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_pc4", pc4_lv1, 32'd0);
    check("wrap_next", imem_addr, 32'd0);

    // No response: bubble into decode
    imem_ready = 1'b0;
    cycle();
    check("bubble_valid", {31'd0, valid_lv1}, 32'd0);
    check("sb_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
